pipe_ctrl: RTL and testbench

- Central control for the next-generation pipelined MIPS CPU, replacing single-cycle PC gating.
- Tracks per-stage valid bits and generates stage-register enables, bubbles/flushes and PC enable from hazard, redirect and go inputs.
- Runs a RUN/DRAIN/HALTED state machine for the halting syscall.
- Owns the performance counters: cycles, conditional branches, unconditional branches, stalls and retired instructions.

---
 rtl/cpu_pipe_pkg.sv | 10 +
 rtl/pipe_event_counter.sv | 19 +
 rtl/pipe_ctrl.sv | 95 +++++++++
 tb/tb_pipe_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared state encoding, stage indices and counter width for the pipeline control
package cpu_pipe_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;
  localparam int IF = 0;
  localparam int ID = 1;
  localparam int EX = 2;
  localparam int MEM = 3;
  localparam int WB = 4;
  localparam int CNT_WIDTH_DEF = 32;
endpackage

// File: rtl/pipe_event_counter.sv
// pipe_event_counter: wrap-around event counter with increment enable
module pipe_event_counter
  import cpu_pipe_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;
  // count qualified events, wrapping naturally at 2^WIDTH
  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else if (i_inc) r_count <= r_count + WIDTH'(1);
  end
  assign o_count = r_count;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stage valid tracking, enables/flushes, halt FSM and performance counters
module pipe_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int STAGES       = 5,
  parameter int BRANCH_STAGE = 2,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 id_load_use,
  input  logic                 id_syscall_halt,
  input  logic                 br_taken,
  input  logic                 jump,
  output logic                 pc_enable,
  output logic [STAGES-1:0]    stage_en,
  output logic [STAGES-1:0]    flush,
  output logic [STAGES-1:0]    stage_valid,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] total_cycles,
  output logic [CNT_WIDTH-1:0] condi_branch_num,
  output logic [CNT_WIDTH-1:0] uncondi_branch_num,
  output logic [CNT_WIDTH-1:0] stall_num,
  output logic [CNT_WIDTH-1:0] instr_retired
);
  state_t r_state, w_state_nxt;
  logic [STAGES-1:0] r_valid, w_valid_nxt, w_en, w_flush;
  logic w_adv, w_redir, w_stall, w_hreq, w_pc_en;
  assign w_adv   = go & (r_state != ST_HALTED);
  assign w_redir = w_adv & (br_taken | jump) & r_valid[BRANCH_STAGE];
  assign w_stall = w_adv & id_load_use & r_valid[ID] & ~w_redir;
  assign w_hreq  = w_adv & (r_state == ST_RUN) & id_syscall_halt & r_valid[ID] & ~w_stall & ~w_redir;
  // next state, next valid bits and per-stage enables/bubbles; everything holds when not advancing
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_en        = '0;
    w_flush     = '0;
    w_pc_en     = 1'b0;
    if (w_adv) begin
      if (r_state == ST_RUN && w_hreq) w_state_nxt = ST_DRAIN;
      else if (r_state == ST_DRAIN && r_valid == '0) w_state_nxt = ST_HALTED;
      w_en        = '1;
      w_pc_en     = (r_state == ST_RUN) & ~w_stall & ~w_hreq;
      w_valid_nxt = {r_valid[STAGES-2:0], w_state_nxt == ST_RUN};
      if (w_stall) begin
        w_en[ID:IF]        = 2'b00;
        w_valid_nxt[ID:IF] = r_valid[ID:IF];
        w_valid_nxt[EX]    = 1'b0;
        w_flush[EX]        = 1'b1;
      end
      for (int i = ID; i <= BRANCH_STAGE; i++) begin
        if (w_redir) begin
          w_valid_nxt[i] = 1'b0;
          w_flush[i]     = 1'b1;
        end
      end
      if (w_hreq) begin
        w_valid_nxt[ID] = 1'b0;
        w_flush[ID]     = 1'b1;
      end
    end
  end
  // state and valid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_valid <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
    end
  end
  assign pc_enable   = w_pc_en;
  assign stage_en    = w_en;
  assign flush       = w_flush;
  assign stage_valid = r_valid;
  assign halted      = (r_state == ST_HALTED);
  pipe_event_counter #(.WIDTH(CNT_WIDTH)) u_cycles (
    .clk(clk), .rst(rst), .i_inc(w_adv), .o_count(total_cycles)
  );
  pipe_event_counter #(.WIDTH(CNT_WIDTH)) u_condi (
    .clk(clk), .rst(rst), .i_inc(w_redir & br_taken & ~jump), .o_count(condi_branch_num)
  );
  pipe_event_counter #(.WIDTH(CNT_WIDTH)) u_uncondi (
    .clk(clk), .rst(rst), .i_inc(w_redir & jump), .o_count(uncondi_branch_num)
  );
  pipe_event_counter #(.WIDTH(CNT_WIDTH)) u_stall (
    .clk(clk), .rst(rst), .i_inc(w_stall), .o_count(stall_num)
  );
  pipe_event_counter #(.WIDTH(CNT_WIDTH)) u_retired (
    .clk(clk), .rst(rst), .i_inc(w_adv & r_valid[STAGES-1]), .o_count(instr_retired)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random stimulus against a reference model with a scoreboard
module tb_pipe_ctrl;
  logic clk, rst, go, id_load_use, id_syscall_halt, br_taken, jump;
  logic pc_enable, halted, w_pc_enable, w_halted;
  logic [4:0] stage_en, flush, stage_valid, w_stage_en, w_flush, w_stage_valid;
  logic [31:0] total_cycles, condi_branch_num, uncondi_branch_num, stall_num, instr_retired;
  logic [2:0] w_tc, w_cb, w_ub, w_sn, w_ir;
  int total = 0;
  int bad = 0;
  typedef struct { logic pc; logic [4:0] en; logic [4:0] fl; } comb_t;
  typedef struct { logic [4:0] v; logic h; logic [31:0] tc, cb, ub, sn, ir; } reg_t;
  comb_t comb_q[$];
  reg_t reg_q[$];
  logic [1:0] m_st;
  logic [4:0] m_v;
  logic [31:0] m_tc, m_cb, m_ub, m_sn, m_ir;

  pipe_ctrl #(.STAGES(5), .BRANCH_STAGE(2), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .go(go), .id_load_use(id_load_use), .id_syscall_halt(id_syscall_halt),
    .br_taken(br_taken), .jump(jump), .pc_enable(pc_enable), .stage_en(stage_en), .flush(flush),
    .stage_valid(stage_valid), .halted(halted), .total_cycles(total_cycles),
    .condi_branch_num(condi_branch_num), .uncondi_branch_num(uncondi_branch_num),
    .stall_num(stall_num), .instr_retired(instr_retired)
  );

  pipe_ctrl #(.STAGES(5), .BRANCH_STAGE(2), .CNT_WIDTH(3)) dut_w (
    .clk(clk), .rst(rst), .go(go), .id_load_use(id_load_use), .id_syscall_halt(id_syscall_halt),
    .br_taken(br_taken), .jump(jump), .pc_enable(w_pc_enable), .stage_en(w_stage_en), .flush(w_flush),
    .stage_valid(w_stage_valid), .halted(w_halted), .total_cycles(w_tc),
    .condi_branch_num(w_cb), .uncondi_branch_num(w_ub), .stall_num(w_sn), .instr_retired(w_ir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic g, input logic lu, input logic sh, input logic bt, input logic jp);
    comb_t c;
    reg_t e;
    logic adv, redir, stall, hreq;
    logic [1:0] ns;
    logic [4:0] nv;
    @(negedge clk);
    rst = r; go = g; id_load_use = lu; id_syscall_halt = sh; br_taken = bt; jump = jp;
    #1;
    adv   = !r && g && m_st != 2'd2;
    redir = adv && (bt || jp) && m_v[2];
    stall = adv && lu && m_v[1] && !redir;
    hreq  = adv && m_st == 2'd0 && sh && m_v[1] && !stall && !redir;
    ns = m_st;
    if (adv && m_st == 2'd0 && hreq) ns = 2'd1;
    if (adv && m_st == 2'd1 && m_v == 5'b0) ns = 2'd2;
    c.pc = adv && m_st == 2'd0 && !stall && !hreq;
    c.en = !adv ? 5'b00000 : stall ? 5'b11100 : 5'b11111;
    c.fl = adv ? {2'b00, stall || redir, redir || hreq, 1'b0} : 5'b00000;
    nv = m_v;
    if (adv) nv = stall ? {m_v[3], m_v[2], 1'b0, m_v[1:0]} : {m_v[3:0], ns == 2'd0};
    if (redir) nv[2:1] = 2'b00;
    if (hreq) nv[1] = 1'b0;
    e.v  = r ? 5'b0 : nv;
    e.h  = !r && ns == 2'd2;
    e.tc = r ? 32'd0 : m_tc + 32'(adv);
    e.cb = r ? 32'd0 : m_cb + 32'(redir && bt && !jp);
    e.ub = r ? 32'd0 : m_ub + 32'(redir && jp);
    e.sn = r ? 32'd0 : m_sn + 32'(stall);
    e.ir = r ? 32'd0 : m_ir + 32'(adv && m_v[4]);
    reg_q.push_back(e);
    if (!r) begin
      comb_q.push_back(c);
      c = comb_q.pop_front();
      chk("pc_enable", 32'(pc_enable), 32'(c.pc));
      chk("stage_en", 32'(stage_en), 32'(c.en));
      chk("flush", 32'(flush), 32'(c.fl));
    end
    @(posedge clk);
    #1;
    m_st = r ? 2'd0 : ns;
    e = reg_q.pop_front();
    m_v = e.v; m_tc = e.tc; m_cb = e.cb; m_ub = e.ub; m_sn = e.sn; m_ir = e.ir;
    chk("stage_valid", 32'(stage_valid), 32'(e.v));
    chk("halted", 32'(halted), 32'(e.h));
    chk("total_cycles", total_cycles, e.tc);
    chk("condi_branch_num", condi_branch_num, e.cb);
    chk("uncondi_branch_num", uncondi_branch_num, e.ub);
    chk("stall_num", stall_num, e.sn);
    chk("instr_retired", instr_retired, e.ir);
    chk("wrap_total_cycles", 32'(w_tc), e.tc % 8);
    chk("wrap_condi", 32'(w_cb), e.cb % 8);
    chk("wrap_uncondi", 32'(w_ub), e.ub % 8);
    chk("wrap_stall", 32'(w_sn), e.sn % 8);
    chk("wrap_retired", 32'(w_ir), e.ir % 8);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; id_load_use = 1'b0; id_syscall_halt = 1'b0; br_taken = 1'b0; jump = 1'b0;
    m_st = 2'd0; m_v = 5'b0; m_tc = 0; m_cb = 0; m_ub = 0; m_sn = 0; m_ir = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1);
    chk("reset_valid", 32'(stage_valid), 32'h0);
    chk("reset_cycles", total_cycles, 32'h0);
    idle(8);
    chk("fill_valid", 32'(stage_valid), 32'h1f);
    chk("fill_cycles", total_cycles, 32'd8);
    step(0, 1, 1, 0, 0, 0);
    chk("stall_bubble", 32'(stage_valid), 32'h1b);
    chk("stall_count", stall_num, 32'd1);
    idle(4);
    step(0, 1, 1, 0, 1, 0);
    chk("redir_over_stall_valid", 32'(stage_valid), 32'h19);
    chk("redir_over_stall_stalls", stall_num, 32'd1);
    chk("redir_over_stall_condi", condi_branch_num, 32'd1);
    idle(4);
    step(0, 1, 0, 0, 1, 1);
    chk("jump_and_br_uncondi", uncondi_branch_num, 32'd1);
    chk("jump_and_br_condi", condi_branch_num, 32'd1);
    idle(4);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("stall_after_freeze", stall_num, 32'd2);
    idle(4);
    step(0, 1, 0, 1, 0, 0);
    chk("drain_valid", 32'(stage_valid), 32'h1c);
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 12 && m_st != 2'd2; n++) idle(1);
    chk("halt_reached", 32'(halted), 32'd1);
    idle(3);
    chk("halted_pc", 32'(pc_enable), 32'd0);
    step(1, 1, 0, 0, 0, 0);
    chk("rst_clears_halt", 32'(halted), 32'd0);
    chk("rst_clears_retired", instr_retired, 32'd0);
    for (int n = 0; n < 300; n++) begin
      if (m_st == 2'd2 && $urandom_range(0, 3) == 0) step(1, 1, 0, 0, 0, 0);
      else step(0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
